// File: rtl/disp_pkg.sv
// Shared definitions for the display-sharing logic.
// Holds the arbiter state encoding, the BCD digit geometry of the 3-digit
// display, and a width helper for sizing counters and index registers.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    BLANK
  } state_t;

  localparam int DIGIT_W  = 4;
  localparam int N_DIGITS = 3;
  localparam int VAL_W    = DIGIT_W * N_DIGITS;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at (last_owner+1) mod N_REQ and reports the first
// set bit as winner; any_req flags that at least one request is pending.
// Ports:
//   req        in   N_REQ   request vector
//   last_owner in   IDX_W   index of the most recent owner
//   winner     out  IDX_W   index of the selected requester (0 when none)
//   any_req    out  1       at least one request bit is set
module disp_rr_pick
  import disp_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = cnt_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  // Scan from the farthest position back to the nearest so the nearest set
  // bit after last_owner is the final assignment; last_owner itself is
  // visited first, so it only wins when it is the sole requester.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last_owner) + k) % N_REQ]) begin
        winner  = IDX_W'((int'(last_owner) + k) % N_REQ);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_share_arbiter.sv
// Round-robin owner of the shared 3-digit seven-segment display.
// Grants the display to one requester at a time, guarantees each contended
// owner DWELL_TICKS cycles, and blanks the display for BLANK_TICKS cycles
// between owners to avoid ghosting. All outputs are registered.
// Ports:
//   clk_70hz  in   1         display-rate clock
//   reset     in   1         asynchronous, active-high
//   req       in   N_REQ     level request per requester
//   val       in   12*N_REQ  {hundreds,tens,ones} BCD per requester
//   grant     out  N_REQ     one-hot current owner, zero when none
//   disp_en   out  1         display multiplexer enable
//   ones      out  4         BCD digit 0
//   tens      out  4         BCD digit 1
//   hundreds  out  4         BCD digit 2
//   busy      out  1         high while owning or blanking
module disp_share_arbiter
  import disp_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int DWELL_TICKS = 140,
  parameter int BLANK_TICKS = 7
) (
  input  logic                   clk_70hz,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [VAL_W*N_REQ-1:0] val,
  output logic [N_REQ-1:0]       grant,
  output logic                   disp_en,
  output logic [DIGIT_W-1:0]     ones,
  output logic [DIGIT_W-1:0]     tens,
  output logic [DIGIT_W-1:0]     hundreds,
  output logic                   busy
);

  localparam int IDX_W   = cnt_width(N_REQ);
  localparam int DWELL_W = cnt_width(DWELL_TICKS);
  localparam int BLANK_W = cnt_width(BLANK_TICKS);

  localparam logic [IDX_W-1:0]   LAST_RESET = IDX_W'(N_REQ - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_TICKS - 1);

  state_t             state, state_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic [IDX_W-1:0]   last_owner, last_owner_n;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
  logic [BLANK_W-1:0] blank_cnt, blank_cnt_n;
  logic [VAL_W-1:0]   digits_n;
  logic [N_REQ-1:0]   grant_n;

  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic [VAL_W-1:0]   own_val;
  logic [VAL_W-1:0]   win_val;
  logic               owner_req;
  logic               others_req;

  disp_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Select the BCD slices of the current owner and of the arbitration winner.
  always_comb begin
    own_val = '0;
    win_val = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == IDX_W'(i)) own_val = val[i*VAL_W +: VAL_W];
      if (winner == IDX_W'(i)) win_val = val[i*VAL_W +: VAL_W];
    end
  end

  // grant is the registered one-hot of owner while in OWN, so it doubles as
  // the mask separating the owner's request from everyone else's.
  assign owner_req  = |(req & grant);
  assign others_req = |(req & ~grant);

  // Next-state logic; every register's next value defaults to holding.
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    dwell_cnt_n  = dwell_cnt;
    blank_cnt_n  = blank_cnt;
    digits_n     = {hundreds, tens, ones};

    case (state)
      IDLE: begin
        if (any_req) begin
          state_n      = OWN;
          owner_n      = winner;
          last_owner_n = winner;
          dwell_cnt_n  = '0;
          digits_n     = win_val;
        end
      end
      OWN: begin
        digits_n = own_val;
        if (!owner_req || (dwell_cnt == DWELL_LAST && others_req)) begin
          state_n     = BLANK;
          blank_cnt_n = '0;
        end else if (dwell_cnt != DWELL_LAST) begin
          dwell_cnt_n = dwell_cnt + DWELL_W'(1);
        end
      end
      BLANK: begin
        if (blank_cnt == BLANK_LAST) begin
          if (any_req) begin
            state_n      = OWN;
            owner_n      = winner;
            last_owner_n = winner;
            dwell_cnt_n  = '0;
            digits_n     = win_val;
          end else begin
            state_n = IDLE;
          end
        end else begin
          blank_cnt_n = blank_cnt + BLANK_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    grant_n = '0;
    if (state_n == OWN) grant_n = {{(N_REQ-1){1'b0}}, 1'b1} << owner_n;
  end

  // State, counters and all outputs are registered from the next-state values.
  always_ff @(posedge clk_70hz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_RESET;
      dwell_cnt  <= '0;
      blank_cnt  <= '0;
      grant      <= '0;
      disp_en    <= 1'b0;
      busy       <= 1'b0;
      ones       <= '0;
      tens       <= '0;
      hundreds   <= '0;
    end else begin
      state                  <= state_n;
      owner                  <= owner_n;
      last_owner             <= last_owner_n;
      dwell_cnt              <= dwell_cnt_n;
      blank_cnt              <= blank_cnt_n;
      grant                  <= grant_n;
      disp_en                <= (state_n == OWN);
      busy                   <= (state_n != IDLE);
      {hundreds, tens, ones} <= digits_n;
    end
  end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Testbench for disp_share_arbiter with N_REQ=3, DWELL_TICKS=4, BLANK_TICKS=1.
// The reference model tracks the owner, how long it has held the display and
// how many blank cycles remain, and is advanced once per clock edge.
module tb_disp_share_arbiter;

  localparam int N  = 3;
  localparam int DW = 4;
  localparam int BL = 1;

  logic            clk_70hz = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [12*N-1:0] val;
  logic [N-1:0]    grant;
  logic            disp_en;
  logic [3:0]      ones;
  logic [3:0]      tens;
  logic [3:0]      hundreds;
  logic            busy;

  int tests = 0;
  int fails = 0;

  int         m_owner;
  int         m_blank_left;
  int         m_held;
  int         m_last;
  logic [11:0] m_digits;

  always #5 clk_70hz = ~clk_70hz;

  disp_share_arbiter #(
    .N_REQ       (N),
    .DWELL_TICKS (DW),
    .BLANK_TICKS (BL)
  ) dut (
    .clk_70hz (clk_70hz),
    .reset    (reset),
    .req      (req),
    .val      (val),
    .grant    (grant),
    .disp_en  (disp_en),
    .ones     (ones),
    .tens     (tens),
    .hundreds (hundreds),
    .busy     (busy)
  );

  task automatic checkOne(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    m_owner      = -1;
    m_blank_left = 0;
    m_held       = 0;
    m_last       = N - 1;
    m_digits     = 12'h000;
  endfunction

  // Hand the display to the next requester after m_last in circular order.
  function automatic void modelStart(input logic [N-1:0] r, input logic [12*N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (m_owner < 0 && r[(m_last + k) % N]) m_owner = (m_last + k) % N;
    end
    m_last   = m_owner;
    m_held   = 1;
    m_digits = v[12*m_owner +: 12];
  endfunction

  function automatic void modelStep(input logic [N-1:0] r, input logic [12*N-1:0] v);
    logic [N-1:0] others;
    if (m_blank_left > 0) begin
      m_blank_left--;
      if (m_blank_left == 0 && r != '0) modelStart(r, v);
    end else if (m_owner >= 0) begin
      m_digits = v[12*m_owner +: 12];
      others   = r & ~(N'(1) << m_owner);
      if (!r[m_owner] || (m_held >= DW && others != '0)) begin
        m_owner      = -1;
        m_blank_left = BL;
      end else begin
        m_held++;
      end
    end else if (r != '0) begin
      modelStart(r, v);
    end
  endfunction

  task automatic checkOutput();
    logic [N-1:0] exp_grant;
    exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    checkOne("grant", 12'(grant), 12'(exp_grant));
    checkOne("disp_en", 12'(disp_en), 12'(m_owner >= 0));
    checkOne("busy", 12'(busy), 12'(m_owner >= 0 || m_blank_left > 0));
    checkOne("digits", {hundreds, tens, ones}, m_digits);
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [12*N-1:0] v);
    req = r;
    val = v;
    @(posedge clk_70hz);
    modelStep(r, v);
    #1;
    checkOutput();
  endtask

  // Assert reset between edges, look at the outputs before any edge arrives,
  // then release it shortly after the following edge.
  task automatic pulseReset();
    #2 reset = 1'b1;
    modelReset();
    #1;
    checkOne("async_rst_grant", 12'(grant), 12'h000);
    checkOne("async_rst_en", 12'(disp_en), 12'h000);
    checkOne("async_rst_digits", {hundreds, tens, ones}, 12'h000);
    checkOne("async_rst_busy", 12'(busy), 12'h000);
    @(posedge clk_70hz);
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0]    r;
    logic [12*N-1:0] v;
    logic [N-1:0]    seq [15];

    reset = 1'b1;
    req   = '0;
    val   = '0;
    modelReset();
    #3;
    checkOutput();
    #9 reset = 1'b0;

    // Single requester: granted one edge after req with its digits loaded.
    applyStimulus(3'b001, {24'h000000, 12'h123});
    checkOne("tp1_grant", 12'(grant), 12'h001);
    checkOne("tp1_disp_en", 12'(disp_en), 12'h001);
    checkOne("tp1_digits", {hundreds, tens, ones}, 12'h123);
    checkOne("tp1_busy", 12'(busy), 12'h001);

    // Two requesters alternate with dwell and blanking.
    v = {12'h999, 12'h000, 12'h111};
    repeat (20) applyStimulus(3'b101, v);
    repeat (4) applyStimulus(3'b000, v);

    // Three requesters rotate 0,1,2,0 with one blank cycle between owners.
    pulseReset();
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
            3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
            3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
    v = {12'h333, 12'h222, 12'h111};
    for (int i = 0; i < 15; i++) begin
      applyStimulus(3'b111, v);
      checkOne("tp3_seq", 12'(grant), 12'(seq[i]));
    end
    applyStimulus(3'b111, v);
    checkOne("tp3_wrap", 12'(grant), 12'h001);

    // Lone owner drops its request: blank, then idle with digits held.
    pulseReset();
    v = {24'h000000, 12'h321};
    repeat (3) applyStimulus(3'b001, v);
    applyStimulus(3'b000, v);
    checkOne("tp4_blank_en", 12'(disp_en), 12'h000);
    checkOne("tp4_blank_busy", 12'(busy), 12'h001);
    applyStimulus(3'b000, v);
    checkOne("tp4_idle_busy", 12'(busy), 12'h000);
    checkOne("tp4_idle_digits", {hundreds, tens, ones}, 12'h321);

    // Lone owner keeps the display indefinitely and tracks val changes.
    for (int i = 0; i < 20; i++) begin
      v = {24'h000000, (i < 10) ? 12'h456 : 12'h789};
      applyStimulus(3'b001, v);
      checkOne("tp5_no_blank", 12'(disp_en), 12'h001);
      if (i == 10) checkOne("tp5_new_digits", {hundreds, tens, ones}, 12'h789);
    end

    // Asynchronous reset mid-OWN, then requester 0 wins first.
    pulseReset();
    applyStimulus(3'b011, {12'h000, 12'h555, 12'h444});
    checkOne("tp6_first", 12'(grant), 12'h001);

    // Randomized request patterns held for random lengths.
    for (int n = 0; n < 120; n++) begin
      r = N'($urandom_range(0, 7));
      for (int c = $urandom_range(1, 12); c > 0; c--) begin
        if ($urandom_range(0, 3) == 0) begin
          v[31:0]  = $urandom();
          v[35:32] = 4'($urandom());
        end
        applyStimulus(r, v);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
